// File: rtl/my_vip_pkg.sv
// Shared video-IP definitions: Avalon-ST packet type codes, the test pattern
// generator FSM encoding and the control-packet nibble packing helper.
package my_vip_pkg;

    localparam logic [3:0] PKT_CTRL        = 4'hF;
    localparam logic [3:0] PKT_VIDEO       = 4'h0;
    localparam logic [3:0] PKT_PROGRESSIVE = 4'h3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_C_HDR = 3'd1;
    localparam logic [2:0] ST_C_D0  = 3'd2;
    localparam logic [2:0] ST_C_D1  = 3'd3;
    localparam logic [2:0] ST_C_D2  = 3'd4;
    localparam logic [2:0] ST_V_HDR = 3'd5;
    localparam logic [2:0] ST_V_PIX = 3'd6;

    // Control payload beat idx (0..2) as {plane2, plane1, plane0} nibbles.
    function automatic logic [11:0] ctrl_nibbles(input logic [15:0] w,
                                                 input logic [15:0] h,
                                                 input logic [1:0]  idx);
        case (idx)
            2'd0:    return {w[7:4], w[11:8], w[15:12]};
            2'd1:    return {h[11:8], h[15:12], w[3:0]};
            default: return {PKT_PROGRESSIVE, h[3:0], h[7:4]};
        endcase
    endfunction

endpackage

// File: rtl/my_tpg_gen_if.sv
// Avalon-ST video stream bundle: data, valid, ready, start/end of packet.
interface my_tpg_gen_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  startofpacket;
    logic                  endofpacket;

    modport master (output data, valid, startofpacket, endofpacket, input ready);
    modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/my_tpg_pixel.sv
// Combinational pattern colour for one pixel. Plane0 = B (LSBs), plane1 = G,
// plane2 = R.
module my_tpg_pixel #(
    parameter int unsigned           DATA_WIDTH   = 24,
    parameter int unsigned           COLOR_BITS   = 8,
    parameter int unsigned           COLOR_PLANES = 3,
    parameter logic [DATA_WIDTH-1:0] SOLID_COLOR  = 24'h808080
) (
    input  logic [1:0]            pattern,
    input  logic [15:0]           x,
    input  logic [15:0]           y,
    input  logic [2:0]            bar,
    output logic [DATA_WIDTH-1:0] color
);

    // Only a few coordinate bits matter to the patterns.
    logic unused_coord;
    assign unused_coord = &{1'b0, x, y};

    // Colour select: bar index bits map straight onto R/G/B on/off.
    always_comb begin
        color = '0;
        case (pattern)
            2'd0: begin
                color[0 +: COLOR_BITS]            = {COLOR_BITS{~bar[0]}};
                color[COLOR_BITS +: COLOR_BITS]   = {COLOR_BITS{~bar[2]}};
                color[2*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{~bar[1]}};
            end
            2'd1: begin
                for (int unsigned p = 0; p < COLOR_PLANES; p++)
                    color[p*COLOR_BITS +: COLOR_BITS] = x[COLOR_BITS-1:0];
            end
            2'd2: begin
                for (int unsigned p = 0; p < COLOR_PLANES; p++)
                    color[p*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{x[4] ^ y[4]}};
            end
            default: color = SOLID_COLOR;
        endcase
    end

endmodule

// File: rtl/my_tpg_gen.sv
// Avalon-ST test pattern generator: control packet + video packet per frame,
// repeated while enable is high at frame boundaries. All outputs registered.
module my_tpg_gen
    import my_vip_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 24,
    parameter int unsigned           COLOR_BITS   = 8,
    parameter int unsigned           COLOR_PLANES = 3,
    parameter logic [15:0]           IM_WIDTH     = 16'd640,
    parameter logic [15:0]           IM_HEIGHT    = 16'd480,
    parameter logic [DATA_WIDTH-1:0] SOLID_COLOR  = 24'h808080
) (
    input  logic                vst_clk,
    input  logic                vst_rst_n,
    input  logic                enable,
    input  logic [1:0]          pattern_sel,
    my_tpg_gen_if.master        dout,
    output logic [15:0]         frame_cnt
);

    localparam logic [15:0] X_LAST       = IM_WIDTH - 16'd1;
    localparam logic [15:0] Y_LAST       = IM_HEIGHT - 16'd1;
    localparam logic [15:0] BAR_W        = IM_WIDTH / 16'd8;
    localparam logic [15:0] BAR_LAST_POS = BAR_W - 16'd1;

    logic [2:0]            state;
    logic [15:0]           x, y, bar_pos;
    logic [2:0]            bar;
    logic [1:0]            pat;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, sop_q, eop_q;

    logic [15:0]           nx, ny, npos;
    logic [2:0]            nbar;
    logic                  last_pix;
    logic [DATA_WIDTH-1:0] pix;
    logic [2:0]            nxt_state;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic                  nxt_valid, nxt_sop, nxt_eop;
    logic                  start, frame_done, adv;

    // Control beat idx expanded to planes: nibble in the low 4 bits of each.
    function automatic logic [DATA_WIDTH-1:0] ctrl_beat(input logic [1:0] idx);
        logic [11:0]           nib;
        logic [DATA_WIDTH-1:0] beat;
        nib  = ctrl_nibbles(IM_WIDTH, IM_HEIGHT, idx);
        beat = '0;
        for (int unsigned p = 0; p < 3; p++)
            beat[p*COLOR_BITS +: 4] = nib[p*4 +: 4];
        return beat;
    endfunction

    assign adv = !valid_q || dout.ready;

    // Coordinates of the pixel following the one on the bus (origin otherwise).
    always_comb begin
        last_pix = (state == ST_V_PIX) && (x == X_LAST) && (y == Y_LAST);
        nx   = '0;
        ny   = '0;
        nbar = '0;
        npos = '0;
        if (state == ST_V_PIX && !last_pix) begin
            if (x == X_LAST) begin
                ny = y + 16'd1;
            end else begin
                nx = x + 16'd1;
                ny = y;
                if (bar_pos == BAR_LAST_POS && bar != 3'd7) begin
                    nbar = bar + 3'd1;
                end else begin
                    nbar = bar;
                    npos = bar_pos + 16'd1;
                end
            end
        end
    end

    my_tpg_pixel #(
        .DATA_WIDTH   (DATA_WIDTH),
        .COLOR_BITS   (COLOR_BITS),
        .COLOR_PLANES (COLOR_PLANES),
        .SOLID_COLOR  (SOLID_COLOR)
    ) u_pixel (
        .pattern (pat),
        .x       (nx),
        .y       (ny),
        .bar     (nbar),
        .color   (pix)
    );

    // Next beat to present once the current one is accepted.
    always_comb begin
        nxt_state  = state;
        nxt_data   = '0;
        nxt_valid  = 1'b1;
        nxt_sop    = 1'b0;
        nxt_eop    = 1'b0;
        start      = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                nxt_valid = 1'b0;
                start     = enable;
            end
            ST_C_HDR: begin
                nxt_state = ST_C_D0;
                nxt_data  = ctrl_beat(2'd0);
            end
            ST_C_D0: begin
                nxt_state = ST_C_D1;
                nxt_data  = ctrl_beat(2'd1);
            end
            ST_C_D1: begin
                nxt_state = ST_C_D2;
                nxt_data  = ctrl_beat(2'd2);
                nxt_eop   = 1'b1;
            end
            ST_C_D2: begin
                nxt_state     = ST_V_HDR;
                nxt_data[3:0] = PKT_VIDEO;
                nxt_sop       = 1'b1;
            end
            ST_V_HDR, ST_V_PIX: begin
                if (last_pix) begin
                    frame_done = 1'b1;
                    start      = enable;
                    nxt_state  = ST_IDLE;
                    nxt_valid  = 1'b0;
                end else begin
                    nxt_state = ST_V_PIX;
                    nxt_data  = pix;
                    nxt_eop   = (nx == X_LAST) && (ny == Y_LAST);
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_valid = 1'b0;
            end
        endcase
        if (start) begin
            nxt_state     = ST_C_HDR;
            nxt_data      = '0;
            nxt_data[3:0] = PKT_CTRL;
            nxt_sop       = 1'b1;
            nxt_eop       = 1'b0;
            nxt_valid     = 1'b1;
        end
    end

    // Output beat, FSM and counters advance only when the bus is free or accepted.
    always_ff @(posedge vst_clk or negedge vst_rst_n) begin
        if (!vst_rst_n) begin
            state     <= ST_IDLE;
            x         <= '0;
            y         <= '0;
            bar       <= '0;
            bar_pos   <= '0;
            pat       <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            frame_cnt <= '0;
        end else if (adv) begin
            state   <= nxt_state;
            x       <= nx;
            y       <= ny;
            bar     <= nbar;
            bar_pos <= npos;
            data_q  <= nxt_data;
            valid_q <= nxt_valid;
            sop_q   <= nxt_sop;
            eop_q   <= nxt_eop;
            if (start)
                pat <= pattern_sel;
            if (frame_done)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign dout.data          = data_q;
    assign dout.valid         = valid_q;
    assign dout.startofpacket = sop_q;
    assign dout.endofpacket   = eop_q;

endmodule

// File: tb/tb_my_tpg_gen.sv
// Directed bench for my_tpg_gen with a 16x2 image.
module tb_my_tpg_gen;

    localparam logic [15:0] W = 16'd16;
    localparam logic [15:0] H = 16'd2;
    localparam int          FB = 37;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    my_tpg_gen_if #(.DATA_WIDTH(24)) dout_if ();

    my_tpg_gen #(
        .DATA_WIDTH   (24),
        .COLOR_BITS   (8),
        .COLOR_PLANES (3),
        .IM_WIDTH     (W),
        .IM_HEIGHT    (H),
        .SOLID_COLOR  (24'h808080)
    ) dut (
        .vst_clk     (clk),
        .vst_rst_n   (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .dout        (dout_if),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    logic [23:0] cap_data[$];
    logic        cap_sop[$];
    logic        cap_eop[$];
    int          cap_cyc[$];
    int          cyc = 0;
    int          hold_err = 0;
    int          stalls = 0;
    logic        stall_prev = 1'b0;
    logic [25:0] prev_beat = '0;

    // Capture accepted beats and watch for changes during stalls.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (!dout_if.valid ||
                {dout_if.startofpacket, dout_if.endofpacket, dout_if.data} !== prev_beat))
                hold_err++;
            stall_prev = dout_if.valid && !dout_if.ready;
            if (stall_prev)
                stalls++;
            prev_beat = {dout_if.startofpacket, dout_if.endofpacket, dout_if.data};
            if (dout_if.valid && dout_if.ready) begin
                cap_data.push_back(dout_if.data);
                cap_sop.push_back(dout_if.startofpacket);
                cap_eop.push_back(dout_if.endofpacket);
                cap_cyc.push_back(cyc);
            end
        end
    end

    // Expected {sop, eop, data} of beat idx within a frame.
    function automatic logic [25:0] exp_beat(input int idx, input logic [1:0] pat);
        logic [23:0] bars [8];
        int          p, xi, yi;
        logic [7:0]  x8;
        logic [23:0] d;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (idx)
            0: return {2'b10, 24'h00000F};
            1: return {2'b00, 24'h010000};
            2: return {2'b00, 24'h000000};
            3: return {2'b01, 24'h030200};
            4: return {2'b10, 24'h000000};
            default: ;
        endcase
        p  = idx - 5;
        xi = p % 16;
        yi = p / 16;
        x8 = 8'(xi);
        case (pat)
            2'd0:    d = bars[3'(xi / 2)];
            2'd1:    d = {x8, x8, x8};
            2'd2:    d = ((xi / 16) % 2 != (yi / 16) % 2) ? 24'hFFFFFF : 24'h000000;
            default: d = 24'h808080;
        endcase
        return {1'b0, (p == 31), d};
    endfunction

    task automatic clear_cap();
        cap_data.delete();
        cap_sop.delete();
        cap_eop.delete();
        cap_cyc.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (cap_data.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (dout_if.valid && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (dout_if.valid !== 1'b0) begin
            $display("FAIL idle_timeout: valid=%b required 0", dout_if.valid);
            fails++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        pattern_sel = 2'd0;
        dout_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests += 5;
        if (dout_if.valid !== 1'b0) begin $display("FAIL rst_valid: got %b required 0", dout_if.valid); fails++; end
        if (dout_if.startofpacket !== 1'b0) begin $display("FAIL rst_sop: got %b required 0", dout_if.startofpacket); fails++; end
        if (dout_if.endofpacket !== 1'b0) begin $display("FAIL rst_eop: got %b required 0", dout_if.endofpacket); fails++; end
        if (dout_if.data !== 24'h0) begin $display("FAIL rst_data: got %h required 000000", dout_if.data); fails++; end
        if (frame_cnt !== 16'd0) begin $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); fails++; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        tests++;
        if (dout_if.valid !== 1'b0) begin $display("FAIL idle_no_enable: valid=%b required 0", dout_if.valid); fails++; end
    endtask

    task automatic test_colour_bars();
        clear_cap();
        pattern_sel = 2'd0;
        enable = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({dout_if.valid, dout_if.startofpacket, dout_if.data} !== {2'b11, 24'h00000F}) begin
            $display("FAIL start_latency: valid/sop/data=%b/%b/%h required 1/1/00000f",
                     dout_if.valid, dout_if.startofpacket, dout_if.data);
            fails++;
        end
        wait_beats(FB, 200);
        tests++;
        if (frame_cnt !== 16'd1) begin $display("FAIL frame_cnt_1: got %0d required 1", frame_cnt); fails++; end
        wait_beats(FB + 1, 20);
        enable = 1'b0;
        for (int i = 0; i < FB; i++) begin
            tests++;
            if (i >= cap_data.size()) begin
                $display("FAIL bars_beat[%0d]: missing, required %h", i, exp_beat(i, 2'd0)); fails++;
            end else if ({cap_sop[i], cap_eop[i], cap_data[i]} !== exp_beat(i, 2'd0)) begin
                $display("FAIL bars_beat[%0d]: got %h required %h", i,
                         {cap_sop[i], cap_eop[i], cap_data[i]}, exp_beat(i, 2'd0)); fails++;
            end
        end
        tests++;
        if (cap_data.size() < FB + 1 || {cap_sop[FB], cap_data[FB]} !== {1'b1, 24'h00000F}
            || cap_cyc[FB] != cap_cyc[FB-1] + 1) begin
            $display("FAIL back_to_back: next C_HDR not on the cycle after last pixel (beats=%0d)", cap_data.size());
            fails++;
        end
        wait_beats(2 * FB, 200);
        wait_idle();
        tests++;
        if (frame_cnt !== 16'd2) begin $display("FAIL frame_cnt_2: got %0d required 2", frame_cnt); fails++; end
    endtask

    task automatic test_random_ready();
        int k = 0;
        int hold0 = hold_err;
        int st0 = stalls;
        clear_cap();
        pattern_sel = 2'd0;
        enable = 1'b1;
        while (cap_data.size() < FB && k < 800) begin
            @(posedge clk); #1;
            dout_if.ready = 1'($urandom_range(0, 1));
            if (cap_data.size() >= 1)
                enable = 1'b0;
            k++;
        end
        dout_if.ready = 1'b1;
        for (int i = 0; i < FB; i++) begin
            tests++;
            if (i >= cap_data.size()) begin
                $display("FAIL rr_beat[%0d]: missing, required %h", i, exp_beat(i, 2'd0)); fails++;
            end else if ({cap_sop[i], cap_eop[i], cap_data[i]} !== exp_beat(i, 2'd0)) begin
                $display("FAIL rr_beat[%0d]: got %h required %h", i,
                         {cap_sop[i], cap_eop[i], cap_data[i]}, exp_beat(i, 2'd0)); fails++;
            end
        end
        tests++;
        if (hold_err != hold0) begin $display("FAIL stall_hold: %0d changes while stalled, required 0", hold_err - hold0); fails++; end
        tests++;
        if (stalls == st0) begin $display("FAIL stall_seen: got 0 stalled cycles, required >0"); fails++; end
        wait_idle();
        tests++;
        if (frame_cnt !== 16'd3 || cap_data.size() != FB) begin
            $display("FAIL rr_frame_end: frame_cnt=%0d beats=%0d required 3/%0d", frame_cnt, cap_data.size(), FB); fails++;
        end
    endtask

    task automatic test_enable_drop();
        clear_cap();
        pattern_sel = 2'd1;
        enable = 1'b1;
        wait_beats(9, 100);
        enable = 1'b0;
        wait_beats(FB, 200);
        for (int i = 0; i < FB; i++) begin
            tests++;
            if (i >= cap_data.size()) begin
                $display("FAIL ramp_beat[%0d]: missing, required %h", i, exp_beat(i, 2'd1)); fails++;
            end else if ({cap_sop[i], cap_eop[i], cap_data[i]} !== exp_beat(i, 2'd1)) begin
                $display("FAIL ramp_beat[%0d]: got %h required %h", i,
                         {cap_sop[i], cap_eop[i], cap_data[i]}, exp_beat(i, 2'd1)); fails++;
            end
        end
        wait_idle();
        repeat (10) @(posedge clk); #1;
        tests++;
        if (dout_if.valid !== 1'b0 || cap_data.size() != FB || frame_cnt !== 16'd4) begin
            $display("FAIL enable_drop_idle: valid=%b beats=%0d frame_cnt=%0d required 0/%0d/4",
                     dout_if.valid, cap_data.size(), frame_cnt, FB); fails++;
        end
    endtask

    task automatic test_pattern_change();
        clear_cap();
        pattern_sel = 2'd0;
        enable = 1'b1;
        wait_beats(15, 100);
        pattern_sel = 2'd2;
        wait_beats(FB + 1, 100);
        enable = 1'b0;
        wait_beats(2 * FB, 200);
        for (int i = 0; i < 2 * FB; i++) begin
            logic [1:0]  pt;
            logic [25:0] e;
            pt = (i < FB) ? 2'd0 : 2'd2;
            e  = exp_beat(i % FB, pt);
            tests++;
            if (i >= cap_data.size()) begin
                $display("FAIL patchg_beat[%0d]: missing, required %h", i, e); fails++;
            end else if ({cap_sop[i], cap_eop[i], cap_data[i]} !== e) begin
                $display("FAIL patchg_beat[%0d]: got %h required %h", i,
                         {cap_sop[i], cap_eop[i], cap_data[i]}, e); fails++;
            end
        end
        wait_idle();
        tests++;
        if (frame_cnt !== 16'd6) begin $display("FAIL frame_cnt_6: got %0d required 6", frame_cnt); fails++; end
    endtask

    task automatic test_solid();
        clear_cap();
        pattern_sel = 2'd3;
        enable = 1'b1;
        wait_beats(1, 50);
        enable = 1'b0;
        wait_beats(FB, 200);
        for (int i = 5; i < FB; i++) begin
            tests++;
            if (i >= cap_data.size()) begin
                $display("FAIL solid_beat[%0d]: missing, required %h", i, exp_beat(i, 2'd3)); fails++;
            end else if ({cap_sop[i], cap_eop[i], cap_data[i]} !== exp_beat(i, 2'd3)) begin
                $display("FAIL solid_beat[%0d]: got %h required %h", i,
                         {cap_sop[i], cap_eop[i], cap_data[i]}, exp_beat(i, 2'd3)); fails++;
            end
        end
        wait_idle();
    endtask

    task automatic test_async_reset();
        clear_cap();
        pattern_sel = 2'd0;
        enable = 1'b1;
        wait_beats(2, 50);
        tests++;
        if ({dout_if.valid, dout_if.startofpacket, dout_if.endofpacket, dout_if.data} !== {3'b100, 24'h0}
            || frame_cnt !== 16'd7) begin
            $display("FAIL pre_reset_c_d1: v/s/e/data=%b%b%b/%h frame_cnt=%0d required 100/000000/7",
                     dout_if.valid, dout_if.startofpacket, dout_if.endofpacket, dout_if.data, frame_cnt);
            fails++;
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({dout_if.valid, dout_if.startofpacket, dout_if.endofpacket} !== 3'b000 || frame_cnt !== 16'd0) begin
            $display("FAIL async_reset: v/s/e=%b%b%b frame_cnt=%0d required 000/0",
                     dout_if.valid, dout_if.startofpacket, dout_if.endofpacket, frame_cnt);
            fails++;
        end
        repeat (2) @(posedge clk); #1;
        clear_cap();
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({dout_if.valid, dout_if.startofpacket, dout_if.data} !== {2'b11, 24'h00000F} || frame_cnt !== 16'd0) begin
            $display("FAIL restart: valid/sop/data=%b/%b/%h frame_cnt=%0d required 1/1/00000f/0",
                     dout_if.valid, dout_if.startofpacket, dout_if.data, frame_cnt);
            fails++;
        end
        wait_beats(1, 20);
        enable = 1'b0;
        wait_beats(FB, 200);
        for (int i = 0; i < FB; i++) begin
            tests++;
            if (i >= cap_data.size()) begin
                $display("FAIL restart_beat[%0d]: missing, required %h", i, exp_beat(i, 2'd0)); fails++;
            end else if ({cap_sop[i], cap_eop[i], cap_data[i]} !== exp_beat(i, 2'd0)) begin
                $display("FAIL restart_beat[%0d]: got %h required %h", i,
                         {cap_sop[i], cap_eop[i], cap_data[i]}, exp_beat(i, 2'd0)); fails++;
            end
        end
        wait_idle();
        tests++;
        if (frame_cnt !== 16'd1) begin $display("FAIL frame_cnt_after_reset: got %0d required 1", frame_cnt); fails++; end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_colour_bars();
        test_random_ready();
        test_enable_drop();
        test_pattern_change();
        test_solid();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
